// File: rtl/exc_sched_if.sv
// Signal bundle between the pipeline/CP0 side (master) and the exception scheduler (slave).
// Timer compare signals are present only when EXC_SCHED_TIMER_INT_EN is defined.
interface exc_sched_if;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        id_bd;
    logic        id_reserved;
    logic        id_syscall;
    logic        id_break;
    logic        id_eret;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_bd;
    logic        ex_overflow;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_bd;
    logic [31:0] mem_addr;
    logic        mem_adel;
    logic        mem_ades;
    logic [7:0]  int_pending;
    logic        status_ie;
    logic        status_exl;
    logic [31:0] epc_in;
    logic        cp0_we;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        exc_bd;
    logic        badv_we;
    logic [31:0] exc_badvaddr;
    logic        set_exl;
    logic        clr_exl;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        busy;
`ifdef EXC_SCHED_TIMER_INT_EN
    logic        cmp_we;
    logic [31:0] cmp_wdata;
    logic        timer_irq;
`endif

    modport master (
`ifdef EXC_SCHED_TIMER_INT_EN
        output cmp_we, cmp_wdata,
        input  timer_irq,
`endif
        output stall, if_valid, if_pc, id_valid, id_pc, id_bd, id_reserved, id_syscall,
               id_break, id_eret, ex_valid, ex_pc, ex_bd, ex_overflow, mem_valid, mem_pc,
               mem_bd, mem_addr, mem_adel, mem_ades, int_pending, status_ie, status_exl, epc_in,
        input  cp0_we, exc_code, exc_epc, exc_bd, badv_we, exc_badvaddr, set_exl, clr_exl,
               flush, redirect, redirect_pc, busy
    );

    modport slave (
`ifdef EXC_SCHED_TIMER_INT_EN
        input  cmp_we, cmp_wdata,
        output timer_irq,
`endif
        input  stall, if_valid, if_pc, id_valid, id_pc, id_bd, id_reserved, id_syscall,
               id_break, id_eret, ex_valid, ex_pc, ex_bd, ex_overflow, mem_valid, mem_pc,
               mem_bd, mem_addr, mem_adel, mem_ades, int_pending, status_ie, status_exl, epc_in,
        output cp0_we, exc_code, exc_epc, exc_bd, badv_we, exc_badvaddr, set_exl, clr_exl,
               flush, redirect, redirect_pc, busy
    );
endinterface

// File: rtl/exc_sched.sv
// CP0 exception/interrupt scheduler: picks the oldest pipeline event and sequences entry/ERET.
// Define EXC_SCHED_TIMER_INT_EN to add the compare timer folded into interrupt line 7.
module exc_sched #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    exc_sched_if.slave bus
);
    localparam int unsigned      CNT_W      = 3;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_COMMIT, S_FLUSH, S_REDIR, S_ERET} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cp0_we_q, cp0_we_d, set_exl_q, set_exl_d, clr_exl_q, clr_exl_d;
    logic             badv_we_q, badv_we_d, flush_q, flush_d, redir_q, redir_d, busy_q, busy_d;
    logic [4:0]       code_q;
    logic [31:0]      epc_q, badv_q, rpc_q;
    logic             bd_q;

    logic [7:0]  irq_vec;
    logic        mem_irq, older_evt, eret_ok, exc_hit, accept_exc, accept_eret;
    logic [4:0]  sel_code;
    logic [31:0] sel_pc, sel_badv, sel_epc;
    logic        sel_bd, sel_has_badv;

`ifdef EXC_SCHED_TIMER_INT_EN
    logic [31:0] count_q, cmp_q;
    logic        tick_q, timer_irq_q;

    // Count advances every second clock; the match flag is sticky until the next compare write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            cmp_q       <= '1;
            tick_q      <= 1'b0;
            timer_irq_q <= 1'b0;
        end else begin
            tick_q <= ~tick_q;
            if (tick_q) count_q <= count_q + 32'd1;
            if (bus.cmp_we) begin
                cmp_q       <= bus.cmp_wdata;
                timer_irq_q <= 1'b0;
            end else if (count_q == cmp_q) begin
                timer_irq_q <= 1'b1;
            end
        end
    end

    assign bus.timer_irq = timer_irq_q;
    assign irq_vec       = {bus.int_pending[7] | timer_irq_q, bus.int_pending[6:0]};
`else
    assign irq_vec = bus.int_pending;
`endif

    // Oldest-first candidate selection; ERET only wins when nothing older than ID is faulting.
    always_comb begin
        mem_irq      = bus.status_ie & ~bus.status_exl & (|irq_vec) & bus.mem_valid;
        older_evt    = mem_irq | (bus.mem_valid & (bus.mem_adel | bus.mem_ades))
                     | (bus.ex_valid & bus.ex_overflow);
        eret_ok      = bus.id_valid & bus.id_eret & ~older_evt;
        exc_hit      = 1'b1;
        sel_code     = 5'd0;
        sel_pc       = bus.mem_pc;
        sel_bd       = bus.mem_bd;
        sel_badv     = bus.mem_addr;
        sel_has_badv = 1'b0;
        if (mem_irq) begin
            sel_code = 5'd0;
        end else if (bus.mem_valid & bus.mem_adel) begin
            sel_code     = 5'd4;
            sel_has_badv = 1'b1;
        end else if (bus.mem_valid & bus.mem_ades) begin
            sel_code     = 5'd5;
            sel_has_badv = 1'b1;
        end else if (bus.ex_valid & bus.ex_overflow) begin
            sel_code = 5'd12;
            sel_pc   = bus.ex_pc;
            sel_bd   = bus.ex_bd;
        end else if (bus.id_valid & (bus.id_reserved | bus.id_syscall | bus.id_break)) begin
            sel_code = bus.id_reserved ? 5'd10 : (bus.id_syscall ? 5'd8 : 5'd9);
            sel_pc   = bus.id_pc;
            sel_bd   = bus.id_bd;
        end else if (bus.if_valid & (bus.if_pc[1:0] != 2'b00)) begin
            sel_code     = 5'd4;
            sel_pc       = bus.if_pc;
            sel_bd       = 1'b0;
            sel_badv     = bus.if_pc;
            sel_has_badv = 1'b1;
        end else begin
            exc_hit = 1'b0;
        end
        sel_epc     = sel_bd ? sel_pc - 32'd4 : sel_pc;
        accept_eret = (state_q == S_IDLE) & ~bus.stall & eret_ok;
        accept_exc  = (state_q == S_IDLE) & ~bus.stall & ~bus.status_exl & exc_hit & ~eret_ok;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_exc)       state_d = S_COMMIT;
                else if (accept_eret) state_d = S_ERET;
            end
            S_COMMIT: begin
                if (FLUSH_CYCLES > 1) begin
                    state_d = S_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else begin
                    state_d = S_REDIR;
                end
            end
            S_FLUSH: begin
                if (!bus.stall) begin
                    if (cnt_q <= CNT_W'(1)) state_d = S_REDIR;
                    else                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            S_REDIR, S_ERET: begin
                if (!bus.stall) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Output flops follow the next state so every strobe comes straight from a register.
        cp0_we_d  = accept_exc;
        set_exl_d = accept_exc;
        badv_we_d = accept_exc & sel_has_badv;
        clr_exl_d = accept_eret;
        flush_d   = (state_d != S_IDLE);
        busy_d    = (state_d != S_IDLE);
        redir_d   = (state_d == S_REDIR) | (state_d == S_ERET);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cp0_we_q  <= 1'b0;
            set_exl_q <= 1'b0;
            clr_exl_q <= 1'b0;
            badv_we_q <= 1'b0;
            flush_q   <= 1'b0;
            redir_q   <= 1'b0;
            busy_q    <= 1'b0;
            code_q    <= '0;
            epc_q     <= '0;
            bd_q      <= 1'b0;
            badv_q    <= '0;
            rpc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cp0_we_q  <= cp0_we_d;
            set_exl_q <= set_exl_d;
            clr_exl_q <= clr_exl_d;
            badv_we_q <= badv_we_d;
            flush_q   <= flush_d;
            redir_q   <= redir_d;
            busy_q    <= busy_d;
            if (accept_exc) begin
                code_q <= sel_code;
                epc_q  <= sel_epc;
                bd_q   <= sel_bd;
                rpc_q  <= EXC_VECTOR;
                if (sel_has_badv) badv_q <= sel_badv;
            end else if (accept_eret) begin
                rpc_q <= bus.epc_in;
            end
        end
    end

    assign bus.cp0_we       = cp0_we_q;
    assign bus.exc_code     = code_q;
    assign bus.exc_epc      = epc_q;
    assign bus.exc_bd       = bd_q;
    assign bus.badv_we      = badv_we_q;
    assign bus.exc_badvaddr = badv_q;
    assign bus.set_exl      = set_exl_q;
    assign bus.clr_exl      = clr_exl_q;
    assign bus.flush        = flush_q;
    // A stalled front end must not see the redirect; it reappears once stall drops.
    assign bus.redirect     = redir_q & ~bus.stall;
    assign bus.redirect_pc  = rpc_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_exc_sched.sv
// Directed bench for exc_sched with a queue-of-steps reference model and per-cycle compare.
// With EXC_SCHED_TIMER_INT_EN defined it also exercises the compare timer.
module tb_exc_sched;
    localparam logic [31:0] VEC = 32'hBFC00380;
    localparam int unsigned FC  = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errs   = 0;

    always #5 clk = ~clk;

    exc_sched_if bus ();
    exc_sched #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic cp0_we; logic set_exl; logic clr_exl; logic badv_we;
        logic flush;  logic redir;   logic stallable;
    } step_t;

    step_t       q[$];
    step_t       hd, ce;
    logic [4:0]  m_code, c_code;
    logic [31:0] m_epc, m_badv, m_rpc, c_pc, c_badv;
    logic        m_bd, c_bd, c_hb, found, mi, me, ee;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic step_t mk(input logic a, input logic b, input logic c, input logic d,
                                 input logic f, input logic r, input logic s);
        step_t t;
        t.cp0_we = a; t.set_exl = b; t.clr_exl = c; t.badv_we = d;
        t.flush = f; t.redir = r; t.stallable = s;
        return t;
    endfunction

    // Reference model: each accepted event becomes a list of per-cycle output steps.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_code = '0; m_epc = '0; m_bd = 1'b0; m_badv = '0; m_rpc = '0;
        end else if (q.size() != 0) begin
            if (!q[0].stallable || !bus.stall) begin
                void'(q.pop_front());
            end else begin
                hd = q[0]; hd.clr_exl = 1'b0; q[0] = hd;
            end
        end else if (!bus.stall) begin
            mi = bus.status_ie && !bus.status_exl && (bus.int_pending != 8'd0) && bus.mem_valid;
            me = bus.mem_valid && (bus.mem_adel || bus.mem_ades);
            ee = bus.ex_valid && bus.ex_overflow;
            if (bus.id_valid && bus.id_eret && !(mi || me || ee)) begin
                m_rpc = bus.epc_in;
                q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
            end else if (!bus.status_exl) begin
                found = 1'b1; c_hb = 1'b0; c_bd = 1'b0; c_badv = 32'd0; c_pc = 32'd0; c_code = 5'd0;
                if (mi) begin
                    c_code = 5'd0; c_pc = bus.mem_pc; c_bd = bus.mem_bd;
                end else if (bus.mem_valid && bus.mem_adel) begin
                    c_code = 5'd4; c_pc = bus.mem_pc; c_bd = bus.mem_bd; c_badv = bus.mem_addr; c_hb = 1'b1;
                end else if (bus.mem_valid && bus.mem_ades) begin
                    c_code = 5'd5; c_pc = bus.mem_pc; c_bd = bus.mem_bd; c_badv = bus.mem_addr; c_hb = 1'b1;
                end else if (ee) begin
                    c_code = 5'd12; c_pc = bus.ex_pc; c_bd = bus.ex_bd;
                end else if (bus.id_valid && bus.id_reserved) begin
                    c_code = 5'd10; c_pc = bus.id_pc; c_bd = bus.id_bd;
                end else if (bus.id_valid && bus.id_syscall) begin
                    c_code = 5'd8; c_pc = bus.id_pc; c_bd = bus.id_bd;
                end else if (bus.id_valid && bus.id_break) begin
                    c_code = 5'd9; c_pc = bus.id_pc; c_bd = bus.id_bd;
                end else if (bus.if_valid && bus.if_pc[1:0] != 2'b00) begin
                    c_code = 5'd4; c_pc = bus.if_pc; c_badv = bus.if_pc; c_hb = 1'b1;
                end else begin
                    found = 1'b0;
                end
                if (found) begin
                    m_code = c_code; m_bd = c_bd; m_rpc = VEC;
                    m_epc  = c_bd ? c_pc - 32'd4 : c_pc;
                    if (c_hb) m_badv = c_badv;
                    q.push_back(mk(1'b1, 1'b1, 1'b0, c_hb, 1'b1, 1'b0, 1'b0));
                    for (int i = 1; i < int'(FC); i++)
                        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
                    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        ce = (q.size() != 0) ? q[0] : step_t'(0);
        chk("busy",     32'(bus.busy),     32'(q.size() != 0));
        chk("cp0_we",   32'(bus.cp0_we),   32'(ce.cp0_we));
        chk("set_exl",  32'(bus.set_exl),  32'(ce.set_exl));
        chk("clr_exl",  32'(bus.clr_exl),  32'(ce.clr_exl));
        chk("badv_we",  32'(bus.badv_we),  32'(ce.badv_we));
        chk("flush",    32'(bus.flush),    32'(ce.flush));
        chk("redirect", 32'(bus.redirect), 32'(ce.redir && !bus.stall));
        if (ce.cp0_we) begin
            chk("exc_code", 32'(bus.exc_code), 32'(m_code));
            chk("exc_epc",  bus.exc_epc, m_epc);
            chk("exc_bd",   32'(bus.exc_bd), 32'(m_bd));
        end
        if (ce.badv_we) chk("badvaddr", bus.exc_badvaddr, m_badv);
        if (ce.redir && !bus.stall) chk("redirect_pc", bus.redirect_pc, m_rpc);
        if (!rst) begin
            chk("rst_code", 32'(bus.exc_code), 32'd0);
            chk("rst_epc",  bus.exc_epc, 32'd0);
            chk("rst_badv", bus.exc_badvaddr, 32'd0);
        end
    end

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_in();
        bus.if_valid = 0; bus.if_pc = 32'h80000000;
        bus.id_valid = 0; bus.id_pc = 32'h80000000; bus.id_bd = 0;
        bus.id_reserved = 0; bus.id_syscall = 0; bus.id_break = 0; bus.id_eret = 0;
        bus.ex_valid = 0; bus.ex_pc = 32'h80000000; bus.ex_bd = 0; bus.ex_overflow = 0;
        bus.mem_valid = 0; bus.mem_pc = 32'h80000000; bus.mem_bd = 0; bus.mem_addr = 0;
        bus.mem_adel = 0; bus.mem_ades = 0; bus.int_pending = 0;
    endtask

    task automatic ex_ovf(input logic [31:0] pc, input logic bd);
        bus.ex_valid = 1; bus.ex_overflow = 1; bus.ex_pc = pc; bus.ex_bd = bd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr_in();
        bus.stall = 0; bus.status_ie = 0; bus.status_exl = 0; bus.epc_in = 0;
`ifdef EXC_SCHED_TIMER_INT_EN
        bus.cmp_we = 0; bus.cmp_wdata = 0;
`endif
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_flush", 32'(bus.flush), 32'd0);
        chk("reset_cp0_we", 32'(bus.cp0_we), 32'd0);
        chk("reset_rpc", bus.redirect_pc, 32'd0);
        next(); next();
        rst = 1'b1;
        next();

        // Overflow: cp0_we at N+1, redirect at N+3, idle at N+4
        ex_ovf(32'h80001000, 1'b0);
        next(); clr_in();
        @(negedge clk);
        chk("t1_cp0_we", 32'(bus.cp0_we), 32'd1);
        chk("t1_code", 32'(bus.exc_code), 32'd12);
        chk("t1_epc", bus.exc_epc, 32'h80001000);
        chk("t1_bd", 32'(bus.exc_bd), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("t1_redirect", 32'(bus.redirect), 32'd1);
        chk("t1_rpc", bus.redirect_pc, 32'hBFC00380);
        @(negedge clk);
        chk("t1_idle", 32'(bus.busy), 32'd0);
        next();

        // MEM AdES in a delay slot beats ID syscall
        bus.mem_valid = 1; bus.mem_ades = 1; bus.mem_pc = 32'h80002004; bus.mem_bd = 1;
        bus.mem_addr = 32'h00000006; bus.id_valid = 1; bus.id_syscall = 1; bus.id_pc = 32'h80002008;
        next(); clr_in();
        @(negedge clk);
        chk("t2_code", 32'(bus.exc_code), 32'd5);
        chk("t2_epc", bus.exc_epc, 32'h80002000);
        chk("t2_bd", 32'(bus.exc_bd), 32'd1);
        chk("t2_badv_we", 32'(bus.badv_we), 32'd1);
        chk("t2_badv", bus.exc_badvaddr, 32'h00000006);
        repeat (6) begin
            @(negedge clk);
        end
        chk("t2_no_followup", 32'(bus.busy), 32'd0);
        next();

        // Interrupt beats MEM AdEL
        bus.int_pending = 8'h04; bus.status_ie = 1; bus.mem_valid = 1; bus.mem_adel = 1;
        bus.mem_addr = 32'h00000013; bus.mem_pc = 32'h80004000;
        next(); clr_in(); bus.status_ie = 0;
        @(negedge clk);
        chk("t3_code", 32'(bus.exc_code), 32'd0);
        chk("t3_badv_we", 32'(bus.badv_we), 32'd0);
        chk("t3_epc", bus.exc_epc, 32'h80004000);
        repeat (3) @(negedge clk);
        next();

        // EX overflow beats ID syscall; delay-slot EPC wraps below zero
        ex_ovf(32'h00000000, 1'b1);
        bus.id_valid = 1; bus.id_syscall = 1;
        next(); clr_in();
        @(negedge clk);
        chk("t4_code", 32'(bus.exc_code), 32'd12);
        chk("t4_epc_wrap", bus.exc_epc, 32'hFFFFFFFC);
        repeat (3) @(negedge clk);
        next();

        // Misaligned fetch
        bus.if_valid = 1; bus.if_pc = 32'h80000006;
        next(); clr_in();
        @(negedge clk);
        chk("t5_code", 32'(bus.exc_code), 32'd4);
        chk("t5_badv", bus.exc_badvaddr, 32'h80000006);
        chk("t5_epc", bus.exc_epc, 32'h80000006);
        repeat (3) @(negedge clk);
        next();

        // ERET with EXL set; epc_in changes after acceptance
        bus.status_exl = 1; bus.id_valid = 1; bus.id_eret = 1; bus.epc_in = 32'h80003000;
        next(); clr_in(); bus.epc_in = 32'h12345678;
        @(negedge clk);
        chk("t6_clr_exl", 32'(bus.clr_exl), 32'd1);
        chk("t6_redirect", 32'(bus.redirect), 32'd1);
        chk("t6_rpc", bus.redirect_pc, 32'h80003000);
        @(negedge clk);
        chk("t6_idle", 32'(bus.busy), 32'd0);
        next();
        bus.id_valid = 1; bus.id_break = 1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_break_ignored", 32'(bus.busy), 32'd0);
        end
        next(); clr_in(); bus.status_exl = 0;

        // Stall at idle blocks acceptance
        bus.stall = 1; ex_ovf(32'h80006000, 1'b0);
        @(negedge clk);
        chk("t7_stall_idle", 32'(bus.busy), 32'd0);
        next();
        @(negedge clk);
        chk("t7_stall_idle2", 32'(bus.busy), 32'd0);
        next(); bus.stall = 0;
        next(); clr_in();
        @(negedge clk);
        chk("t7_accept", 32'(bus.cp0_we), 32'd1);
        repeat (3) @(negedge clk);
        next();

        // Stall held three cycles in REDIR
        ex_ovf(32'h80005000, 1'b0);
        next(); clr_in();
        next();
        next(); bus.stall = 1;
        repeat (3) begin
            @(negedge clk);
            chk("t8_redirect_stalled", 32'(bus.redirect), 32'd0);
            chk("t8_flush_stalled", 32'(bus.flush), 32'd1);
            next();
        end
        bus.stall = 0;
        @(negedge clk);
        chk("t8_redirect_resume", 32'(bus.redirect), 32'd1);
        @(negedge clk);
        chk("t8_idle", 32'(bus.busy), 32'd0);
        next();

        // Reset while flushing
        ex_ovf(32'h80007000, 1'b0);
        next(); clr_in();
        next();
        rst = 1'b0;
        #1;
        chk("t9_flush", 32'(bus.flush), 32'd0);
        chk("t9_busy", 32'(bus.busy), 32'd0);
        chk("t9_code", 32'(bus.exc_code), 32'd0);
        chk("t9_epc", bus.exc_epc, 32'd0);
        next(); rst = 1'b1;
        next();

`ifdef EXC_SCHED_TIMER_INT_EN
        begin
            int cyc;
            rst = 1'b0;
            next(); rst = 1'b1;
            bus.cmp_we = 1; bus.cmp_wdata = 32'd10;
            next(); bus.cmp_we = 0;
            cyc = 0;
            while (!bus.timer_irq && cyc < 60) begin
                next();
                cyc++;
            end
            chk("timer_irq", 32'(bus.timer_irq), 32'd1);
            chk("timer_latency", 32'(cyc >= 15 && cyc <= 30), 32'd1);
        end
`endif
        next();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
